// File: rtl/ex_mem_flag_stage.sv
// EX/MEM boundary register with the architectural Z/V/N flag register.
// Branch conditions are evaluated against the committed flags and registered for MEM.
module ex_mem_flag_stage #(
    parameter int         WIDTH    = 16,
    parameter logic [2:0] FLAG_RST = 3'b000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [3:0]       ex_opcode,
    input  logic [WIDTH-1:0] ex_dst,
    input  logic             ex_ov,
    input  logic             ex_zr,
    input  logic             ex_neg,
    input  logic [3:0]       ex_rd,
    input  logic             ex_we,
    input  logic             ex_br,
    input  logic [2:0]       ex_cond,
    input  logic             stall,
    input  logic             flush,
    output logic             mem_valid,
    output logic [WIDTH-1:0] mem_dst,
    output logic [3:0]       mem_rd,
    output logic             mem_we,
    output logic             mem_br_taken,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_NOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;

    localparam logic [2:0] CC_NE   = 3'b000;
    localparam logic [2:0] CC_EQ   = 3'b001;
    localparam logic [2:0] CC_GT   = 3'b010;
    localparam logic [2:0] CC_LT   = 3'b011;
    localparam logic [2:0] CC_GTE  = 3'b100;
    localparam logic [2:0] CC_LTE  = 3'b101;
    localparam logic [2:0] CC_OVFL = 3'b110;

    logic       adv;
    logic       upd_all;
    logic       upd_z;
    logic       cond_true;
    logic [2:0] flags;   // {Z, V, N}

    assign adv    = ex_valid & ~stall & ~flush;
    assign flag_z = flags[2];
    assign flag_v = flags[1];
    assign flag_n = flags[0];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        upd_all = 1'b0;
        upd_z   = 1'b0;
        unique case (ex_opcode)
            OP_ADD, OP_SUB:                         upd_all = 1'b1;
            OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA: upd_z   = 1'b1;
            default: ;
        endcase
    end

    // Conditions look only at the committed flags; a flag-setter one cycle ahead has already written them.
    always_comb begin
        cond_true = 1'b0;
        case (ex_cond)
            CC_NE:   cond_true = ~flag_z;
            CC_EQ:   cond_true = flag_z;
            CC_GT:   cond_true = ~flag_z & ~flag_n;
            CC_LT:   cond_true = flag_n;
            CC_GTE:  cond_true = flag_z | (~flag_z & ~flag_n);
            CC_LTE:  cond_true = flag_n | flag_z;
            CC_OVFL: cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid    <= 1'b0;
            mem_dst      <= '0;
            mem_rd       <= '0;
            mem_we       <= 1'b0;
            mem_br_taken <= 1'b0;
        end else if (flush) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            mem_valid    <= 1'b0;
            mem_we       <= 1'b0;
            mem_br_taken <= 1'b0;
        end else if (!stall) begin
            mem_valid    <= ex_valid;
            mem_dst      <= ex_dst;
            mem_rd       <= ex_rd;
            mem_we       <= ex_we & ex_valid;
            mem_br_taken <= ex_valid & ex_br & cond_true;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= FLAG_RST;
        end else if (adv) begin
            if (upd_all)
                flags <= {ex_zr, ex_ov, ex_neg};
            else if (upd_z)
                flags[2] <= ex_zr;
        end
    end

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Scoreboard bench for ex_mem_flag_stage: a behavioural model pushes the expected
// post-edge state when stimulus is driven; it is popped and compared after the edge.
module tb_ex_mem_flag_stage;

    localparam int WIDTH = 16;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] dst;
        logic [3:0]       rd;
        logic             we;
        logic             br;
        logic [2:0]       flags;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             ex_valid;
    logic [3:0]       ex_opcode;
    logic [WIDTH-1:0] ex_dst;
    logic             ex_ov, ex_zr, ex_neg;
    logic [3:0]       ex_rd;
    logic             ex_we, ex_br;
    logic [2:0]       ex_cond;
    logic             stall, flush;
    logic             mem_valid;
    logic [WIDTH-1:0] mem_dst;
    logic [3:0]       mem_rd;
    logic             mem_we, mem_br_taken;
    logic             flag_z, flag_v, flag_n;

    int   checks   = 0;
    int   failures = 0;
    exp_t model;
    exp_t sb_q[$];

    ex_mem_flag_stage #(.WIDTH(WIDTH), .FLAG_RST(3'b000)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_dst(ex_dst),
        .ex_ov(ex_ov), .ex_zr(ex_zr), .ex_neg(ex_neg),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_br(ex_br), .ex_cond(ex_cond),
        .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_rd(mem_rd),
        .mem_we(mem_we), .mem_br_taken(mem_br_taken),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cond_eval(input logic [2:0] cc, input logic [2:0] f);
        logic z, v, n;
        {z, v, n} = f;
        case (cc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic compare_state(input string tag, input exp_t e);
        check({tag, ".valid"}, 32'(mem_valid), 32'(e.valid));
        check({tag, ".dst"},   32'(mem_dst),   32'(e.dst));
        check({tag, ".rd"},    32'(mem_rd),    32'(e.rd));
        check({tag, ".we"},    32'(mem_we),    32'(e.we));
        check({tag, ".br"},    32'(mem_br_taken), 32'(e.br));
        check({tag, ".flags"}, 32'({flag_z, flag_v, flag_n}), 32'(e.flags));
    endtask

    // Drive one cycle of stimulus, predict the post-edge state, then compare after the edge.
    task automatic step(input string tag, input logic v, input logic [3:0] op,
                        input logic [WIDTH-1:0] dst, input logic zr, input logic ov,
                        input logic ng, input logic [3:0] rd, input logic we,
                        input logic br, input logic [2:0] cc, input logic st, input logic fl);
        exp_t nx;
        ex_valid = v;  ex_opcode = op; ex_dst = dst; ex_zr = zr; ex_ov = ov; ex_neg = ng;
        ex_rd = rd;    ex_we = we;     ex_br = br;   ex_cond = cc; stall = st; flush = fl;
        nx = model;
        if (fl) begin
            nx.valid = 1'b0; nx.we = 1'b0; nx.br = 1'b0;
        end else if (!st) begin
            nx.valid = v; nx.dst = dst; nx.rd = rd; nx.we = we & v;
            nx.br = v & br & cond_eval(cc, model.flags);
        end
        if (v && !st && !fl) begin
            if (op == 4'b0000 || op == 4'b0010)
                nx.flags = {zr, ov, ng};
            else if (op >= 4'b0011 && op <= 4'b0111)
                nx.flags[2] = zr;
        end
        sb_q.push_back(nx);
        model = nx;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            compare_state(tag, sb_q.pop_front());
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_opcode = 4'hF; ex_dst = '0; ex_zr = 0; ex_ov = 0; ex_neg = 0;
        ex_rd = 0; ex_we = 0; ex_br = 0; ex_cond = 0; stall = 0; flush = 0;
    endtask

    initial begin
        idle_inputs();
        model = '0;
        rst = 1'b1;
        #12;
        compare_state("reset", '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADD producing zero, then branches on the freshly written Z
        step("add",    1, 4'b0000, 16'h0000, 1, 0, 0, 4'd3, 1, 0, 3'b000, 0, 0);
        check("add_flags", 32'({flag_z, flag_v, flag_n}), 32'(3'b100));
        step("br_eq",  1, 4'b1111, 16'h1234, 0, 0, 0, 4'd0, 0, 1, 3'b001, 0, 0);
        check("br_eq_taken", 32'(mem_br_taken), 32'd1);
        step("br_ne",  1, 4'b1111, 16'h1234, 0, 0, 0, 4'd0, 0, 1, 3'b000, 0, 0);
        check("br_ne_taken", 32'(mem_br_taken), 32'd0);

        // SUB sets all three; AND touches Z only
        step("sub",    1, 4'b0010, 16'h8001, 0, 1, 1, 4'd5, 1, 0, 3'b000, 0, 0);
        step("and",    1, 4'b0011, 16'h0001, 0, 0, 0, 4'd6, 1, 0, 3'b000, 0, 0);
        check("and_flags", 32'({flag_z, flag_v, flag_n}), 32'(3'b011));
        step("br_ovfl", 1, 4'b1111, 16'h0000, 0, 0, 0, 4'd0, 0, 1, 3'b110, 0, 0);
        check("br_ovfl_taken", 32'(mem_br_taken), 32'd1);
        step("br_lt",  1, 4'b1111, 16'h0000, 0, 0, 0, 4'd0, 0, 1, 3'b011, 0, 0);
        check("br_lt_taken", 32'(mem_br_taken), 32'd1);
        step("br_gt",  1, 4'b1111, 16'h0000, 0, 0, 0, 4'd0, 0, 1, 3'b010, 0, 0);

        // Non-flag opcodes pass the result through untouched
        step("paddsb", 1, 4'b0001, 16'h7F80, 1, 1, 1, 4'd7, 1, 0, 3'b000, 0, 0);
        check("paddsb_dst", 32'(mem_dst), 32'h7F80);
        step("lw",     1, 4'b1000, 16'hBEEF, 1, 1, 1, 4'd8, 1, 0, 3'b000, 0, 0);
        check("lw_flags", 32'({flag_z, flag_v, flag_n}), 32'(3'b011));

        // Stall holds everything; release captures the waiting SUB
        step("stall1", 1, 4'b0010, 16'h0000, 1, 0, 0, 4'd9, 1, 0, 3'b000, 1, 0);
        step("stall2", 1, 4'b0010, 16'h0000, 1, 0, 0, 4'd9, 1, 0, 3'b000, 1, 0);
        check("stall_dst", 32'(mem_dst), 32'hBEEF);
        step("unstall", 1, 4'b0010, 16'h0000, 1, 0, 0, 4'd9, 1, 0, 3'b000, 0, 0);
        check("unstall_flags", 32'({flag_z, flag_v, flag_n}), 32'(3'b100));

        // Flush beats stall; then normal capture resumes
        step("flush_stall", 1, 4'b0000, 16'h5555, 0, 1, 1, 4'd10, 1, 0, 3'b000, 1, 1);
        check("flush_valid", 32'(mem_valid), 32'd0);
        step("resume", 1, 4'b0011, 16'hAAAA, 0, 0, 0, 4'd11, 1, 1, 3'b111, 0, 0);
        step("bubble", 0, 4'b0000, 16'h3333, 0, 1, 1, 4'd12, 1, 1, 3'b111, 0, 0);

        // Random traffic including branches with we=1
        for (int i = 0; i < 60; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom), 16'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                 1'($urandom), 3'($urandom), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 7) == 0));
        end

        // Async reset mid-stream with flags=111 and mem_valid=1
        step("pre_rst", 1, 4'b0010, 16'hFFFF, 1, 1, 1, 4'd15, 1, 0, 3'b000, 0, 0);
        check("pre_rst_flags", 32'({flag_z, flag_v, flag_n}), 32'(3'b111));
        check("pre_rst_valid", 32'(mem_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model = '0;
        compare_state("async_rst", model);
        #1;
        rst = 1'b0;
        step("post_rst", 1, 4'b0000, 16'h0042, 0, 0, 1, 4'd2, 1, 0, 3'b000, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
